// File: rtl/c17_bist_ctrl.sv
// BIST sequencer for the c17 benchmark: 5-bit LFSR stimulus, programmable settle time,
// 8-bit MISR response compaction and golden-signature compare.
module c17_bist_ctrl #(
  parameter logic [4:0]  SEED       = 5'b00001,
  parameter int unsigned PAT_CNT    = 31,
  parameter int unsigned SETTLE_CYC = 2,
  parameter logic [7:0]  SIG_INIT   = 8'h00,
  parameter logic [7:0]  GOLDEN_SIG = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [4:0] pat_o,
  input  logic [1:0] resp_i,
  output logic       busy,
  output logic       done,
  output logic [7:0] signature,
  output logic       pass
);

  localparam int unsigned     SC_W     = $clog2(SETTLE_CYC) + 1;
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [4:0]      SEED_EFF = (SEED == 5'd0) ? 5'd1 : SEED;
  localparam logic [SC_W-1:0] SET_LOAD = SC_W'(SETTLE_CYC - 1);
  localparam logic [4:0]      VEC_LAST = 5'(PAT_CNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      pat_q, pat_d;
  logic [7:0]      sig_q, sig_d;
  logic [4:0]      vec_q, vec_d;
  logic [SC_W-1:0] set_q, set_d;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    sig_d   = sig_q;
    vec_d   = vec_q;
    set_d   = set_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pat_d   = SEED_EFF;
          sig_d   = SIG_INIT;
          vec_d   = '0;
          set_d   = SET_LOAD;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (set_q == '0) state_d = S_CAPTURE;
        else             set_d   = set_q - 1'b1;
      end
      S_CAPTURE: begin
        sig_d = {sig_q[6:0], sig_q[7] ^ sig_q[5] ^ sig_q[4] ^ sig_q[3]} ^ {6'b0, resp_i};
        vec_d = vec_q + 1'b1;
        if (vec_q == VEC_LAST) begin
          state_d = S_DONE;
        end else begin
          pat_d   = {pat_q[3:0], pat_q[4] ^ pat_q[2]};
          set_d   = SET_LOAD;
          state_d = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      sig_q   <= '0;
      vec_q   <= '0;
      set_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      sig_q   <= sig_d;
      vec_q   <= vec_d;
      set_q   <= set_d;
    end
  end

  assign pat_o     = pat_q;
  assign signature = sig_q;
  assign busy      = (state_q == S_SETTLE) || (state_q == S_CAPTURE);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (sig_q == GOLDEN_SIG);

endmodule
